// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit holding the HI/LO registers
// Optional MADD/MADDU/MSUB/MSUBU support is built when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

  localparam logic [1:0] MODE_SET  = 2'd0;
  localparam logic [1:0] MODE_ADD  = 2'd1;
  localparam logic [1:0] MODE_SUB  = 2'd2;
  localparam logic [1:0] MODE_NONE = 2'd3;

  typedef enum logic {IDLE, BUSY} stateT;

  stateT       state, stateNext;
  logic [4:0]  count;
  logic [63:0] pending;
  logic [1:0]  pendMode;

  logic        accept, isMul, isDiv, signedOp, isAcc, isSub;
  logic [63:0] mulA, mulB, product, result;
  logic        negA, negB;
  logic [31:0] absA, absB, divisor, qMag, rMag, quot, rem;
  logic [1:0]  mode;

  assign accept = start && !cancel && (state == IDLE);

  always_comb begin
    isMul    = 1'b0;
    isDiv    = 1'b0;
    signedOp = 1'b0;
    isAcc    = 1'b0;
    isSub    = 1'b0;
    case (op)
      OP_MULT:  begin isMul = 1'b1; signedOp = 1'b1; end
      OP_MULTU: isMul = 1'b1;
      OP_DIV:   begin isDiv = 1'b1; signedOp = 1'b1; end
      OP_DIVU:  isDiv = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin isMul = 1'b1; signedOp = 1'b1; isAcc = 1'b1; end
      OP_MADDU: begin isMul = 1'b1; isAcc = 1'b1; end
      OP_MSUB:  begin isMul = 1'b1; signedOp = 1'b1; isAcc = 1'b1; isSub = 1'b1; end
      OP_MSUBU: begin isMul = 1'b1; isAcc = 1'b1; isSub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // One 64x64 multiplier serves both signednesses: operands are extended, product kept mod 2^64.
  always_comb begin
    mulA    = signedOp ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
    mulB    = signedOp ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
    product = mulA * mulB;
  end

  // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with a zero remainder.
  always_comb begin
    negA    = signedOp && rs_val[31];
    negB    = signedOp && rt_val[31];
    absA    = negA ? -rs_val : rs_val;
    absB    = negB ? -rt_val : rt_val;
    divisor = (rt_val == 32'd0) ? 32'd1 : absB;
    qMag    = absA / divisor;
    rMag    = absA % divisor;
    quot    = (negA ^ negB) ? -qMag : qMag;
    rem     = negA ? -rMag : rMag;
  end

  always_comb begin
    result = isDiv ? {rem, quot} : product;
    if (isDiv && rt_val == 32'd0) mode = MODE_NONE;
    else if (isAcc)               mode = isSub ? MODE_SUB : MODE_ADD;
    else                          mode = MODE_SET;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept && (isMul || isDiv)) stateNext = BUSY;
      BUSY: if (count == 5'd1) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      count    <= 5'd0;
      pending  <= 64'd0;
      pendMode <= MODE_SET;
    end else begin
      busy <= (stateNext == BUSY);
      if (accept) begin
        if (isMul || isDiv) begin
          pending  <= result;
          pendMode <= mode;
          count    <= isDiv ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
        end else if (op == OP_MTHI) begin
          hi <= rs_val;
        end else if (op == OP_MTLO) begin
          lo <= rs_val;
        end
      end
      if (state == BUSY) begin
        if (count == 5'd1) begin
          count <= 5'd0;
          // Accumulating ops read {hi,lo} here, at commit, not at acceptance.
          case (pendMode)
            MODE_SET: {hi, lo} <= pending;
            MODE_ADD: {hi, lo} <= {hi, lo} + pending;
            MODE_SUB: {hi, lo} <= {hi, lo} - pending;
            default: ;
          endcase
        end else begin
          count <= count - 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - scoreboard bench for mdu_unit
// Covers MADD-family ops when MDU_MADD_EN is defined.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rsVal = 32'd0;
  logic [31:0] rtVal = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    string       tag;
    logic [63:0] res;
    int          cycles;
  } expT;
  expT sbQ[$];

  always #5 clk = ~clk;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rsVal), .rt_val(rtVal), .cancel(cancel),
    .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
    start = 1'b1; op = o; rsVal = a; rtVal = b; cancel = c;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 4'd0;
  endtask

  task automatic issueExp(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] res, input int cyc);
    expT e;
    e.tag = tag; e.res = res; e.cycles = cyc;
    sbQ.push_back(e);
    issue(o, a, b, 1'b0);
  endtask

  task automatic waitDone();
    int  n;
    expT e;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (sbQ.size() == 0) begin
      checkValue("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sbQ.pop_front();
      checkValue({e.tag, "_cycles"}, 64'(n), 64'(e.cycles));
      checkValue(e.tag, {hi, lo}, e.res);
    end
  endtask

  task automatic idleCheck(input string tag, input logic [63:0] expHiLo);
    logic sawBusy;
    sawBusy = 1'b0;
    repeat (12) begin
      sawBusy = sawBusy | busy;
      @(negedge clk);
    end
    checkValue({tag, "_busy"}, 64'(sawBusy), 64'd0);
    checkValue({tag, "_hilo"}, {hi, lo}, expHiLo);
  endtask

  initial begin
    int          ia, ib;
    longint      p;
    logic [31:0] a, b;
    logic [63:0] held;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkValue("reset_busy", 64'(busy), 64'd0);
    checkValue("reset_hilo", {hi, lo}, 64'd0);

    issueExp("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5);
    waitDone();
    issueExp("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 5);
    waitDone();
    issueExp("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10);
    waitDone();
    issueExp("divu", 4'd4, 32'd7, 32'd2, 64'h00000001_00000003, 10);
    waitDone();
    issueExp("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10);
    waitDone();

    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      ia = a; ib = b;
      p = longint'(ia) * longint'(ib);
      issueExp("rand_mult", 4'd1, a, b, p, 5);
      waitDone();
      b = (b == 32'd0 || b == 32'hFFFFFFFF) ? 32'd3 : b;
      b = (i[0]) ? {28'd0, b[3:0] | 4'd1} : b;
      ib = b;
      issueExp("rand_div", 4'd3, a, b, {32'(ia % ib), 32'(ia / ib)}, 10);
      waitDone();
    end

    issue(4'd5, 32'h12345678, 32'd0, 1'b0);
    checkValue("mthi_hi", 64'(hi), 64'h12345678);
    checkValue("mthi_busy", 64'(busy), 64'd0);
    issue(4'd6, 32'h9ABCDEF0, 32'd0, 1'b0);
    checkValue("mtlo_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
    checkValue("mtlo_busy", 64'(busy), 64'd0);

    issue(4'd5, 32'h0000AAAA, 32'd0, 1'b0);
    issue(4'd6, 32'h00005555, 32'd0, 1'b0);
    issueExp("div_zero", 4'd3, 32'd100, 32'd0, 64'h0000AAAA_00005555, 10);
    waitDone();

    issue(4'd1, 32'd3, 32'd3, 1'b1);
    idleCheck("cancel", 64'h0000AAAA_00005555);
    issue(4'd7, 32'd3, 32'd3, 1'b0);
    idleCheck("illegal_op", 64'h0000AAAA_00005555);
`ifndef MDU_MADD_EN
    issue(4'd8, 32'd3, 32'd3, 1'b0);
    idleCheck("madd_off", 64'h0000AAAA_00005555);
`endif

    issue(4'd1, 32'd5, 32'd5, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkValue("async_rst_busy", 64'(busy), 64'd0);
    checkValue("async_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idleCheck("post_rst", 64'd0);
    issueExp("mult_after_rst", 4'd1, 32'd5, 32'd5, 64'd25, 5);
    waitDone();

`ifdef MDU_MADD_EN
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    issueExp("maddu", 4'd9, 32'd1, 32'd1, 64'h00000001_00000000, 5);
    waitDone();
    issueExp("msub", 4'd10, 32'd1, 32'd2, 64'h00000000_FFFFFFFE, 5);
    waitDone();
    held = {hi, lo};
    issueExp("madd_neg", 4'd8, 32'hFFFFFFFF, 32'd2, held - 64'd2, 5);
    waitDone();
`else
    held = {hi, lo};
    checkValue("final_hilo", held, 64'd25);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage, directly downstream of operand forwarding.
- Consumes the forwarded rs/rt values of the instruction in E.
- Runs multi-cycle MULT/MULTU/DIV/DIVU and MTHI/MTLO; holds the HI/LO architectural registers.
- Exposes a busy flag to the stall logic and HI/LO read data to the E-stage result mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (and MADD-family when enabled); legal range 1..31.
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU; legal range 1..31.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  E-stage instruction is an MDU op, qualified by op.
- op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU; others NOP.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- cancel  input  1  exception/interrupt flush of the E-stage instruction this cycle.
- busy  output  1  operation in flight (registered).
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset values: busy=0, hi=0, lo=0, cycle counter=0, state=IDLE. Reset mid-operation aborts it; no HI/LO update follows.
- States: IDLE, BUSY.
- Accept condition: start=1, cancel=0, state=IDLE.
  - An accepted op that is not a legal code is a NOP.
  - In BUSY, start is ignored; the stall logic guarantees it never arrives.
- IDLE, accepted MULT/MULTU/DIV/DIVU/MADD-family:
  - Compute the 64-bit result from the operands sampled that cycle and hold it in a pending register.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES) and go to BUSY.
- BUSY:
  - busy=1 for exactly N consecutive cycles, starting the cycle after acceptance.
  - Counter decrements each edge.
  - On the edge ending the Nth busy cycle: hi/lo <- pending, busy -> 0, state -> IDLE.
  - An op accepted in the first idle cycle after completion is legal (back-to-back).
- MTHI/MTLO accepted in IDLE: hi (resp. lo) <- rs_val at the next edge. No busy cycle.
- hi/lo change only at the defined commit edges. MFHI/MFLO issued while busy is stalled externally; the unit does not guard it.
- cancel:
  - Suppresses a same-cycle start completely: no busy, no HI/LO change.
  - Has no effect on an operation already in BUSY.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32 -> 64; hi=[63:32], lo=[31:0].
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (rt_val=0): operation still occupies DIV_CYCLES busy cycles; hi/lo are left unchanged at commit.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 8..11 accepted.
  - MADD/MADDU: {hi,lo} <- {hi,lo} + signed/unsigned product, mod 2^64.
  - MSUB/MSUBU: {hi,lo} <- {hi,lo} - product, mod 2^64.
  - The {hi,lo} used is the value at commit time; MULT_CYCLES latency.
- Undefined: op 8..11 are NOPs; no busy, no HI/LO change.

Test Plan:
- Reset then MULT rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9(-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 in consecutive cycles -> busy never asserts; hi=0x12345678, lo=0x9ABCDEF0 one edge after each.
- DIV rt=0 with hi=0xAAAA, lo=0x5555 preloaded -> busy 10 cycles; hi/lo unchanged. MULT with cancel=1 same cycle -> busy stays 0, hi/lo unchanged.
- Assert reset asynchronously during busy cycle 3 of MULT 5x5 -> busy, hi, lo drop to 0 before the next edge; no later commit. Next MULT 5x5 -> lo=25 after 5 cycles.
- MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 -> hi=1, lo=0 after 5 cycles. Then MSUB rs=1, rt=2 -> hi=0, lo=0xFFFFFFFE.
